div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
// PURPOSE
//  Execute-stage front/back end for the unsigned sequential divider (seq_divider).
//  - Accepts RV32M DIV/DIVU/REM/REMU ops from the pipeline on a valid/ready handshake.
//  - Converts signed operands to magnitudes and drives the divider's start/operand ports.
//  - Consumes the divider's quotient/remainder and applies sign correction.
//  - Resolves divide-by-zero and signed overflow locally, without using the divider.
//  - Returns the selected result, with its tag, on a valid/ready output.
// PARAMETERS
//  WIDTH  32  operand/result width; must equal the divider's WIDTH
//  TAG_W  5   width of the pass-through tag (destination register index)
// PORTS
//  clk            in   1       single clock; all state on posedge clk
//  rst_n          in   1       reset, asynchronous assert, active-low
//  in_valid       in   1       op request
//  in_ready       out  1       high only in IDLE
//  in_op          in   2       00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//  in_a           in   WIDTH   dividend (rs1)
//  in_b           in   WIDTH   divisor (rs2)
//  in_tag         in   TAG_W   returned unchanged on out_tag
//  flush          in   1       kill the op currently held
//  out_valid      out  1       result available
//  out_ready      in   1       consumer accepts the result
//  out_result     out  WIDTH   quotient (DIV/DIVU) or remainder (REM/REMU)
//  out_tag        out  TAG_W   tag of the op
//  div_start      out  1       one-cycle start pulse to the divider
//  div_dividend   out  WIDTH   magnitude of the dividend
//  div_divisor    out  WIDTH   magnitude of the divisor
//  div_busy       in   1       divider busy; rises one cycle after start
//  div_quotient   in   WIDTH   unsigned quotient; valid once div_busy falls
//  div_remainder  in   WIDTH   unsigned remainder; valid once div_busy falls
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous)
//  - state=IDLE; out_valid=0; div_start=0.
//  - out_result, out_tag, div_dividend, div_divisor are all 0.
//  Acceptance
//  - An op is accepted on in_valid & in_ready.
//  - On acceptance, op, tag, operands, neg_q and neg_r are latched.
//  - signed = (op==DIV | op==REM).
//  - neg_q = signed & (a[MSB] ^ b[MSB]) & (b!=0).
//  - neg_r = signed & a[MSB].
//  Operand magnitudes
//  - Signed ops: each operand is passed as its two's-complement magnitude.
//  - 0x8000_0000 passes through unchanged; it is valid as an unsigned value.
//  FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, FIX, RESP, DRAIN
//  - IDLE -> RESP when accepting with b==0. Result:
//      quotient = all ones; remainder = a.
//  - IDLE -> RESP when accepting a signed op with a==MIN_INT and b==all ones. Result:
//      quotient = MIN_INT; remainder = 0.
//  - IDLE -> ISSUE on any other accept.
//  - ISSUE: div_start=1 for exactly this cycle; -> WAIT_BUSY.
//  - WAIT_BUSY: wait for div_busy=1; -> WAIT_DONE.
//  - WAIT_DONE: wait for div_busy=0; then capture div_quotient/div_remainder; -> FIX.
//  - FIX: negate the quotient if neg_q; negate the remainder if neg_r; select by op; -> RESP.
//  - RESP: out_valid=1. out_result and out_tag stay stable until out_ready.
//    - On out_ready: -> IDLE.
//  - Fast-path (special-case) latency: result visible the cycle after acceptance.
//  - Divider latency: ISSUE + divider run + FIX.
//  Flush
//  - flush in ISSUE, WAIT_BUSY or WAIT_DONE -> DRAIN.
//  - flush in FIX or RESP -> IDLE, and out_valid drops the same cycle.
//  - flush in IDLE has no effect.
//  - A flush in ISSUE still emits the start pulse, so the divider state stays known.
//  - DRAIN: wait for div_busy to rise, then fall; discard the result; -> IDLE.
//    - in_ready stays low throughout DRAIN.
//    - No out_valid is produced for a flushed op.
//  Other rules
//  - div_dividend and div_divisor are held stable from ISSUE through WAIT_DONE.
//  - flush and out_ready high together in RESP: the flush wins; the handshake does not count.
//  - Assertions:
//    - div_start is never high while div_busy=1.
//    - out_valid implies state==RESP.
// TESTING
//  1. DIV a=0xFFFF_FFF9 (-7), b=2 -> out_result=0xFFFF_FFFD (-3); REM same operands -> 0xFFFF_FFFF (-1).
//  2. DIVU a=100, b=7 -> 14; REMU -> 2. Exactly one div_start pulse per op.
//  3. DIV 5/0 -> 0xFFFF_FFFF; REMU 5/0 -> 5; DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000, REM -> 0.
//     In each case: no div_start, and out_valid the next cycle.
//  4. out_ready held low 10 cycles in RESP -> out_valid, result and tag stable; in_ready=0.
//  5. flush during WAIT_DONE -> DRAIN until div_busy falls; no out_valid; next op returns the correct result.
//  6. rst_n pulsed low mid-WAIT_DONE -> outputs 0 immediately and state IDLE.
//     Divider also reset; next DIVU 9/3 -> 3.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
//   Execute-stage wrapper around the unsigned sequential divider. It accepts
//   RV32M DIV/DIVU/REM/REMU ops, converts signed operands to magnitudes,
//   starts the divider, applies sign correction to its quotient/remainder and
//   returns the selected result with its tag. Divide-by-zero and signed
//   overflow are answered locally without starting the divider.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready             op request handshake (ready only in IDLE)
//   in_op                         00 DIV, 01 DIVU, 10 REM, 11 REMU
//   in_a, in_b, in_tag            dividend, divisor, pass-through tag
//   flush                         kill the op currently held
//   out_valid/out_ready           result handshake
//   out_result, out_tag           selected result and its tag
//   div_start                     one-cycle start pulse to the divider
//   div_dividend, div_divisor     operand magnitudes to the divider
//   div_busy                      divider busy (rises one cycle after start)
//   div_quotient, div_remainder   divider results, valid once busy falls
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_busy,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_FIX,
        S_RESP,
        S_DRAIN
    } state_t;

    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_t           state, state_nxt;
    logic [1:0]       op_r;
    logic             neg_q_r, neg_r_r;
    logic [WIDTH-1:0] q_raw, r_raw;
    logic             drain_seen;   // divider busy already observed for the killed op

    logic             accept, signed_op, b_zero, ovf;
    logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;

    // Request decode and sign handling. MIN_INT negates to itself, which is
    // exactly its unsigned magnitude, so no special case is needed here.
    always_comb begin
        accept    = in_valid & in_ready;
        signed_op = ~in_op[0];
        b_zero    = (in_b == '0);
        ovf       = signed_op & (in_a == MIN_INT) & (in_b == ALL_ONES);
        a_mag     = (signed_op & in_a[WIDTH-1]) ? -in_a : in_a;
        b_mag     = (signed_op & in_b[WIDTH-1]) ? -in_b : in_b;
        q_fix     = neg_q_r ? -q_raw : q_raw;
        r_fix     = neg_r_r ? -r_raw : r_raw;
    end

    assign in_ready  = (state == S_IDLE);
    assign div_start = (state == S_ISSUE);
    // A flush in RESP retracts the result in the same cycle.
    assign out_valid = (state == S_RESP) & ~flush;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (accept) state_nxt = (b_zero | ovf) ? S_RESP : S_ISSUE;
            S_ISSUE:     state_nxt = flush ? S_DRAIN : S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (flush)         state_nxt = S_DRAIN;
                else if (div_busy) state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (flush)          state_nxt = S_DRAIN;
                else if (!div_busy) state_nxt = S_FIX;
            end
            S_FIX:       state_nxt = flush ? S_IDLE : S_RESP;
            S_RESP:      if (flush | out_ready) state_nxt = S_IDLE;
            S_DRAIN:     if (drain_seen & ~div_busy) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // NOTE: every datapath register is reset, because the outputs it drives
    // must read zero while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r         <= '0;
            neg_q_r      <= 1'b0;
            neg_r_r      <= 1'b0;
            q_raw        <= '0;
            r_raw        <= '0;
            drain_seen   <= 1'b0;
            out_result   <= '0;
            out_tag      <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_r         <= in_op;
                        out_tag      <= in_tag;
                        neg_q_r      <= signed_op & (in_a[WIDTH-1] ^ in_b[WIDTH-1]) & ~b_zero;
                        neg_r_r      <= signed_op & in_a[WIDTH-1];
                        div_dividend <= a_mag;
                        div_divisor  <= b_mag;
                        if (b_zero)   out_result <= in_op[1] ? in_a : ALL_ONES;
                        else if (ovf) out_result <= in_op[1] ? '0 : MIN_INT;
                    end
                end
                S_WAIT_DONE: begin
                    if (!div_busy) begin
                        q_raw <= div_quotient;
                        r_raw <= div_remainder;
                    end
                end
                S_FIX:   out_result <= op_r[1] ? r_fix : q_fix;
                default: ;
            endcase

            // Entering DRAIN from WAIT_DONE (or with busy already up) means the
            // rising edge of busy is behind us; only the fall remains to wait for.
            if (state != S_DRAIN && state_nxt == S_DRAIN)
                drain_seen <= (state == S_WAIT_DONE) | div_busy;
            else if (state == S_DRAIN && div_busy)
                drain_seen <= 1'b1;
        end
    end

    a_no_start_when_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(div_start && div_busy));
    a_valid_only_in_resp: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> (state == S_RESP));

endmodule

// File: tb/tb_div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_issue_ctrl
//   Directed bench for div_issue_ctrl. A small behavioural sequential divider
//   answers the start pulse: busy rises one cycle after start, stays high for
//   DLAT cycles, and the quotient/remainder read as junk until busy falls.
//   Expected results are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_div_issue_ctrl;

    localparam int DLAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a, in_b;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        div_start;
    logic [31:0] div_dividend, div_divisor;
    logic        div_busy;
    logic [31:0] div_quotient, div_remainder;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_start = 0;

    div_issue_ctrl #(.WIDTH(32), .TAG_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_tag        (in_tag),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_tag       (out_tag),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_busy      (div_busy),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    always #5 clk = ~clk;

    // Behavioural divider.
    int          cnt;
    logic [31:0] pend_q, pend_r;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_busy      <= 1'b0;
            cnt           <= 0;
            pend_q        <= '0;
            pend_r        <= '0;
            div_quotient  <= '0;
            div_remainder <= '0;
        end else if (div_start && !div_busy) begin
            div_busy      <= 1'b1;
            cnt           <= DLAT;
            pend_q        <= (div_divisor == 0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
            pend_r        <= (div_divisor == 0) ? div_dividend  : div_dividend % div_divisor;
            div_quotient  <= 32'hDEAD_BEEF;
            div_remainder <= 32'hBAD0_BAD0;
        end else if (div_busy) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                div_busy      <= 1'b0;
                div_quotient  <= pend_q;
                div_remainder <= pend_r;
            end
        end
    end

    always @(posedge clk) if (div_start) n_start <= n_start + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
        int n = 0;
        in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        check("accept_wait", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // cyc = 1 means out_valid was already up one cycle after acceptance.
    task automatic wait_result(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 100) begin @(negedge clk); cyc++; end
        check("resp_wait", 32'(out_valid), 32'd1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp, input bit fast);
        int cyc;
        int s0 = n_start;
        send(op, a, b, tag);
        wait_result(cyc);
        check({name, "_result"}, out_result, exp);
        check({name, "_tag"}, 32'(out_tag), 32'(tag));
        if (fast) begin
            check({name, "_fast_latency"}, 32'(cyc), 32'd1);
            check({name, "_no_start"}, 32'(n_start - s0), 32'd0);
        end else begin
            check({name, "_one_start"}, 32'(n_start - s0), 32'd1);
        end
        take();
        check({name, "_released"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s0;
        int cyc;
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
        in_tag = '0; flush = 1'b0; out_ready = 1'b0;

        // Reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_div_dividend", div_dividend, 32'd0);
        check("rst_div_divisor", div_divisor, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Signed and unsigned divider-path ops
        run_op("div_m7_2",  2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("rem_m7_2",  2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 1'b0);
        run_op("div_7_m2",  2'b00, 32'd7, 32'hFFFF_FFFE, 5'd3, 32'hFFFF_FFFD, 1'b0);
        run_op("rem_7_m2",  2'b10, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'd1, 1'b0);
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 1'b0);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd6, 32'd2, 1'b0);
        run_op("div_min_2",  2'b00, 32'h8000_0000, 32'd2, 5'd7, 32'hC000_0000, 1'b0);
        run_op("div_min_m2", 2'b00, 32'h8000_0000, 32'hFFFF_FFFE, 5'd8, 32'h4000_0000, 1'b0);
        run_op("divu_min_ones", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 1'b0);
        run_op("remu_min_ones", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b0);

        // Fast path: divide by zero and signed overflow
        run_op("div_5_0",   2'b00, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1'b1);
        run_op("remu_5_0",  2'b11, 32'd5, 32'd0, 5'd12, 32'd5, 1'b1);
        run_op("rem_m7_0",  2'b10, 32'hFFFF_FFF9, 32'd0, 5'd13, 32'hFFFF_FFF9, 1'b1);
        run_op("div_ovf",   2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1'b1);
        run_op("rem_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1'b1);

        // Back-pressure: result and tag hold while out_ready is low
        send(2'b01, 32'd100, 32'd7, 5'd9);
        wait_result(cyc);
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", out_result, 32'd14);
            check("hold_tag", 32'(out_tag), 32'd9);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        take();

        // Flush in RESP together with out_ready: valid drops at once, flush wins
        send(2'b00, 32'd5, 32'd0, 5'd3);
        wait_result(cyc);
        flush = 1'b1; out_ready = 1'b1;
        #1;
        check("resp_flush_valid_drop", 32'(out_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        check("resp_flush_idle", 32'(in_ready), 32'd1);
        check("resp_flush_no_valid", 32'(out_valid), 32'd0);

        // Flush during WAIT_DONE -> DRAIN until busy falls, no result
        s0 = n_start;
        send(2'b01, 32'd50, 32'd5, 5'd4);
        n = 0;
        while (!div_busy && n < 50) begin @(negedge clk); n++; end
        check("drain_busy_rise", 32'(div_busy), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n = 0;
        while (div_busy && n < 50) begin
            check("drain_in_ready", 32'(in_ready), 32'd0);
            check("drain_no_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
            n++;
        end
        check("drain_busy_fall", 32'(div_busy), 32'd0);
        check("drain_last_cycle", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("drain_back_idle", 32'(in_ready), 32'd1);
        check("drain_after_valid", 32'(out_valid), 32'd0);
        check("drain_one_start", 32'(n_start - s0), 32'd1);
        run_op("post_drain_divu", 2'b01, 32'd100, 32'd7, 5'd17, 32'd14, 1'b0);

        // Asynchronous reset mid-WAIT_DONE
        send(2'b00, 32'h8000_0000, 32'hFFFF_FFFE, 5'd21);
        n = 0;
        while (!div_busy && n < 50) begin @(negedge clk); n++; end
        check("rstmid_busy", 32'(div_busy), 32'd1);
        @(negedge clk);
        check("rstmid_dividend_mag", div_dividend, 32'h8000_0000);
        check("rstmid_divisor_mag", div_divisor, 32'd2);
        rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", 32'(out_valid), 32'd0);
        check("rstmid_in_ready", 32'(in_ready), 32'd1);
        check("rstmid_div_start", 32'(div_start), 32'd0);
        check("rstmid_out_result", out_result, 32'd0);
        check("rstmid_out_tag", 32'(out_tag), 32'd0);
        check("rstmid_div_dividend", div_dividend, 32'd0);
        check("rstmid_div_divisor", div_divisor, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_rst_divu", 2'b01, 32'd9, 32'd3, 5'd2, 32'd3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
